// File: rtl/serial_alu_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
// SERIAL_ALU_SUB_EN (optional) enables the SUB opcode in serial_alu_ctrl.
package serial_alu_pkg;

    localparam logic [2:0] OP_XOR = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: xor/and/or/full-add selected by op[1:0].
// cout is forced low for the logic ops so the carry chain stays clean.
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       out,
    output logic       cout
);

    always_comb begin
        out  = a ^ b;
        cout = 1'b0;
        case (op)
            OP_AND[1:0]: out = a & b;
            OP_OR[1:0]:  out = a | b;
            OP_ADD[1:0]: begin
                out  = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one slice, WIDTH cycles LSB first, start/busy/done handshake.
// Optional macro SERIAL_ALU_SUB_EN adds op 100 (a-b); otherwise op 100 runs as XOR.
//
//   state  | meaning
//   S_IDLE | waiting for start; operands and op latched on acceptance
//   S_RUN  | one slice cycle per clock, cnt counts 0..WIDTH-1
//   S_DONE | done pulse; result/carry_out/zero valid, return to idle
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sr;
    logic [1:0]       op_q;
    logic             carry;
    logic [CNTW-1:0]  cnt;

    logic             slice_b;
    logic             slice_out;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ALU_SUB_EN
    logic             sub_q;
    assign slice_b = sb[0] ^ sub_q;
`else
    assign slice_b = sb[0];
`endif

    // Only WIDTH-1 bits are stored; the final bit lands straight in result.
    assign res_next = {slice_out, sr};

    alu_bit_slice u_slice (
        .a    (sa[0]),
        .b    (slice_b),
        .cin  (carry),
        .op   (op_q),
        .out  (slice_out),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            op_q      <= OP_XOR[1:0];
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ALU_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
`ifdef SERIAL_ALU_SUB_EN
                        sub_q <= (op == OP_SUB);
                        carry <= (op == OP_SUB);
`else
                        carry <= 1'b0;
`endif
                        case (op)
                            OP_AND:  op_q <= OP_AND[1:0];
                            OP_OR:   op_q <= OP_OR[1:0];
                            OP_ADD:  op_q <= OP_ADD[1:0];
`ifdef SERIAL_ALU_SUB_EN
                            OP_SUB:  op_q <= OP_ADD[1:0];
`endif
                            default: op_q <= OP_XOR[1:0];
                        endcase
                    end
                end
                S_RUN: begin
                    sr    <= res_next[WIDTH-1:1];
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= slice_cout;
                    cnt   <= cnt + CNTW'(1);
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        result    <= res_next;
                        carry_out <= slice_cout;
                        zero      <= (res_next == '0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_serial_alu_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] last_res = '0;
    logic             last_c   = 1'b0;
    logic             last_z   = 1'b0;

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {carry, result} from the opcode's arithmetic meaning.
    function automatic logic [WIDTH:0] model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        case (o)
            3'd1: r = {1'b0, x & y};
            3'd2: r = {1'b0, x | y};
            3'd3: r = {1'b0, x} + {1'b0, y};
`ifdef SERIAL_ALU_SUB_EN
            3'd4: r = {(x >= y), x - y};
`endif
            default: r = {1'b0, x ^ y};
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] op_i, input logic [WIDTH-1:0] a_i,
                          input logic [WIDTH-1:0] b_i, input bit disturb);
        logic [WIDTH:0] exp;
        int hit_k;
        int busy_cnt;
        int n_done;
        int pos;
        exp = model(op_i, a_i, b_i);
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        hit_k = -1;
        n_done = 0;
        pos = disturb ? int'($urandom_range(1, WIDTH - 1)) : -1;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            if (disturb) begin
                a = $urandom; b = $urandom; op = 3'($urandom);
                start = (k == pos);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (hit_k < 0) begin
                    hit_k = k;
                    check_eq("result", result, exp[WIDTH-1:0]);
                    check_eq("carry_out", carry_out, exp[WIDTH]);
                    check_eq("zero", zero, exp[WIDTH-1:0] == '0);
                end
            end else if (hit_k < 0 && (k % 8) == 0) begin
                check_eq("result_hold", result, last_res);
            end
        end
        check_eq("latency", hit_k, WIDTH);
        check_eq("busy_cycles", busy_cnt, WIDTH + 1);
        check_eq("done_count", n_done, 1);
        last_res = exp[WIDTH-1:0];
        last_c   = exp[WIDTH];
        last_z   = (exp[WIDTH-1:0] == '0);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_carry"}, carry_out, 0);
        check_eq({tag, "_zero"}, zero, 0);
    endtask

    task automatic reset_mid_op();
        int seen;
        @(negedge clk);
        op = 3'd0; a = $urandom | 32'h1; b = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < WIDTH + 8; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check_eq("rst_no_done", seen, 0);
        check_cleared("rst_mid");
        last_res = '0; last_c = 1'b0; last_z = 1'b0;
    endtask

    task automatic back_to_back();
        logic [WIDTH:0] pend;
        int last_done;
        int n_done;
        last_done = -1;
        n_done = 0;
        @(negedge clk);
        op = 3'd3; a = $urandom; b = $urandom; start = 1'b1;
        pend = model(op, a, b);
        for (int e = 0; e < 3 * (WIDTH + 2); e++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                check_eq("b2b_result", result, pend[WIDTH-1:0]);
                check_eq("b2b_carry", carry_out, pend[WIDTH]);
                if (last_done >= 0) check_eq("b2b_period", e - last_done, WIDTH + 2);
                else check_eq("b2b_first", e, WIDTH);
                last_done = e;
                last_res = pend[WIDTH-1:0];
                last_c = pend[WIDTH];
                last_z = (pend[WIDTH-1:0] == '0);
                op = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom;
                pend = model(op, a, b);
            end else if (last_done >= 0) begin
                check_eq("b2b_hold", result, last_res);
            end
        end
        start = 1'b0;
        check_eq("b2b_count", n_done, 3);
        repeat (3) @(posedge clk);
        #1;
        check_eq("b2b_idle", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset_n = 1'b1;

        run_op(3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        run_op(3'd3, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        reset_mid_op();
        run_op(3'd2, 32'h00FF_0000, 32'h0000_FF00, 1'b0);
        run_op(3'd4, 32'd5, 32'd7, 1'b0);
        run_op(3'd4, 32'd7, 32'd5, 1'b0);
        run_op(3'd4, 32'd9, 32'd9, 1'b0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom));
        end
        back_to_back();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
